// File: rtl/hilo_multu.sv
// Sequential 32x32 unsigned multiplier owning the MIPS HI/LO pair.
// MULTU runs a fixed 32-step shift-add loop; HI/LO are written once at the end.
module hilo_multu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [1:0]  state_dbg
);

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] prod_q, prod_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Signal == F_MULTU) begin
          mcand_d  = {32'b0, dataA};
          mplier_d = dataB;
          prod_d   = 64'b0;
          cnt_d    = 5'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // No early exit on a zero multiplier: latency is data independent.
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        hi_d    = prod_q[63:32];
        lo_d    = prod_q[31:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= 64'b0;
      mplier_q <= 32'b0;
      prod_q   <= 64'b0;
      cnt_q    <= 5'd0;
      hi_q     <= 32'b0;
      lo_q     <= 32'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Upstream handshake: while stall is high the EX instruction is held and
  // re-presented each cycle; a held MULTU is accepted on the first IDLE cycle.
  assign busy      = (state_q != IDLE);
  assign stall     = busy && ((Signal == F_MULTU) || (Signal == F_MFHI) ||
                              (Signal == F_MFLO));
  assign HiOut     = hi_q;
  assign LoOut     = lo_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
